xfer_ctrl: RTL and testbench
============================

// Module: xfer_ctrl
// PURPOSE
// - Timeslot controller for the 4x4 VOQ crossbar; sits directly downstream of sched.
// - Each slot it pulses sched_en, captures the grant on sched_sel_en and drives the
//   crossbar for SLOT_LEN cycles, one word per active ingress per cycle.
// - Tracks per-ingress packet progress and feeds is_busy/busy_voq_num back to sched,
//   so packets longer than a slot continue into the next slot.
// - Pops the VOQ head (deq) when a packet's last word leaves.
// PARAMETERS
// - NUM_PORTS  4   ingress = egress count; port index width PW = $clog2(NUM_PORTS) = 2
// - LEN_W      6   packet length field width, in words
// - SLOT_LEN   8   crossbar cycles per timeslot (>= 1)
// - WAIT_MAX   16  cycles to wait for sched_sel_en before a slot proceeds without new grants
// PORTS
// - clk            in   1        system clock
// - reset_n        in   1        synchronous, active-low reset
// - enable         in   1        0: finish the current slot, then park in IDLE
// - voq_empty      in   16       bit 4*i+e: ingress i VOQ for egress e is empty
// - head_len       in   4*LEN_W  [LEN_W*i +: LEN_W]: length of the head packet of the VOQ ingress i is granted
// - sched_sel_en   in   1        sched grant valid (level)
// - sched_sel      in   8        [2i+1:2i]: egress (VOQ) granted to ingress i
// - sched_en       out  1        one-cycle scheduling request
// - is_busy        out  4        ingress i has a packet in flight
// - busy_voq_num   out  8        [2i+1:2i]: VOQ of the in-flight packet of ingress i
// - xbar_valid     out  4        egress e carries a word this cycle
// - xbar_sel       out  8        [2e+1:2e]: ingress driving egress e
// - deq            out  4        one-cycle pulse: pop the head of VOQ busy_voq_num[i] of ingress i
// - err_conflict   out  1        sticky: a grant mapped two ingresses to one egress
// BEHAVIOUR
// - Reset (reset_n=0 at a clk edge): state=IDLE; all outputs and counters 0; err_conflict cleared.
// - FSM states: IDLE, REQ, WAIT, XFER.
// - IDLE: go to REQ when enable=1.
// - REQ: sched_en=1 for exactly this cycle, then go to WAIT. sched_sel_en is ignored in REQ
//   (it may be stale high).
// - WAIT: on the first cycle with sched_sel_en=1, capture the grant and go to XFER next cycle.
//   After WAIT_MAX cycles without it, go to XFER with no new grants.
// - Grant capture, for each ingress i with is_busy[i]=0 and !voq_empty[4i+sel_i]:
//   - set rem[i] = (head_len_i == 0) ? 1 : head_len_i;
//   - set busy_voq_num[i] = sel_i and is_busy[i] = 1.
//   - Ingresses with is_busy[i]=1 keep their VOQ; sched_sel for them is ignored.
//   - Conflict: if two active ingresses target one egress, the lower index wins, the higher
//     index's grant is discarded (not captured), and err_conflict is set.
// - XFER: lasts exactly SLOT_LEN cycles; a slot counter runs from SLOT_LEN-1 down to 0.
//   In every XFER cycle, for each ingress i with rem[i] != 0:
//   - xbar_valid[busy_voq_num[i]] = 1 and xbar_sel[busy_voq_num[i]] = i;
//   - rem[i] decrements (LEN_W-bit, never wraps below 0);
//   - if rem[i] == 1: pulse deq[i] that cycle and clear is_busy[i] the next cycle.
//   - Outside XFER, xbar_valid = 0.
// - At slot counter 0: go to REQ if enable=1, else IDLE. Busy state is kept across IDLE.
// - is_busy/busy_voq_num are registered and change only at grant capture or a packet's last word.
// - Back-to-back slots have a 2-cycle gap (REQ + at least 1 WAIT cycle).
// - Reset mid-slot aborts the transfer: in-flight packets are not dequeued.
// STRUCTURE
// - Shared package xfer_pkg: NUM_PORTS, PW, LEN_W, the state enum, and function
//   egress_conflict(sel, act) returning a per-ingress discard mask.
// - One sub-module, port_xfer: per-ingress rem counter, VOQ register and deq generation;
//   instantiated NUM_PORTS times.
// - Crossbar select mux and FSM are in the top level.
// TESTING
// - Grant {i0->e2, others empty}, head_len=3, SLOT_LEN=8: xbar_valid[2]=1 with xbar_sel[5:4]=0
//   for 3 cycles; deq[0] pulses on the 3rd cycle; is_busy=0 at the next sched_en.
// - head_len=11, SLOT_LEN=8: is_busy[0]=1 and busy_voq_num[1:0] held at the next sched_en;
//   3 more words in slot 2, then deq[0].
// - Grant i1->e3 and i2->e3: only i1 transfers; err_conflict=1 and stays 1 until reset.
// - sched_sel_en high during REQ, low afterwards: stale grant ignored; after WAIT_MAX cycles
//   the slot runs with no new grants.
// - head_len=0: treated as 1 word, with deq in the first XFER cycle.
// - Reset asserted mid-XFER: the next cycle shows all outputs 0 and state IDLE; no deq pulse.

Source files
------------

// File: rtl/xfer_pkg.sv
// Shared types and helpers for the crossbar timeslot controller.
// Holds the port geometry, the FSM state type and the grant conflict resolver.
package xfer_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PW        = $clog2(NUM_PORTS);
    localparam int unsigned LEN_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_XFER
    } state_e;

    // Lower ingress index wins an egress; every higher claimant is discarded.
    function automatic logic [NUM_PORTS-1:0] egress_conflict(
        input logic [NUM_PORTS*PW-1:0] sel,
        input logic [NUM_PORTS-1:0]    act
    );
        logic [NUM_PORTS-1:0] discard;
        discard = '0;
        for (int unsigned i = 1; i < NUM_PORTS; i++) begin
            for (int unsigned j = 0; j < i; j++) begin
                if (act[i] && act[j] && (sel[PW*i +: PW] == sel[PW*j +: PW]))
                    discard[i] = 1'b1;
            end
        end
        return discard;
    endfunction

endpackage

// File: rtl/xfer_ctrl_port_xfer.sv
// Per-ingress packet tracker: remaining-word counter, granted VOQ and dequeue pulse.
// A zero-length head packet is moved as a single word.
module port_xfer
    import xfer_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [PW-1:0]    load_voq,
    input  logic [LEN_W-1:0] load_len,
    input  logic             step,
    output logic             busy,
    output logic             active,
    output logic             deq,
    output logic [PW-1:0]    voq
);

    logic [LEN_W-1:0] rem_q, rem_d;
    logic [PW-1:0]    voq_q, voq_d;
    logic             busy_q, busy_d;

    assign active = step && (rem_q != '0);
    assign deq    = active && (rem_q == LEN_W'(1));
    assign busy   = busy_q;
    assign voq    = voq_q;

    always_comb begin
        rem_d  = rem_q;
        voq_d  = voq_q;
        busy_d = busy_q;
        if (load) begin
            rem_d  = (load_len == '0) ? LEN_W'(1) : load_len;
            voq_d  = load_voq;
            busy_d = 1'b1;
        end else if (active) begin
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1))
                busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rem_q  <= '0;
            voq_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            voq_q  <= voq_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/xfer_ctrl.sv
// Timeslot controller for the 4x4 VOQ crossbar: requests a schedule, captures the
// grant, and drives the crossbar for SLOT_LEN cycles per slot.
module xfer_ctrl
    import xfer_pkg::*;
#(
    parameter int unsigned SLOT_LEN = 8,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] voq_empty,
    input  logic [NUM_PORTS*LEN_W-1:0]     head_len,
    input  logic                           sched_sel_en,
    input  logic [NUM_PORTS*PW-1:0]        sched_sel,
    output logic                           sched_en,
    output logic [NUM_PORTS-1:0]           is_busy,
    output logic [NUM_PORTS*PW-1:0]        busy_voq_num,
    output logic [NUM_PORTS-1:0]           xbar_valid,
    output logic [NUM_PORTS*PW-1:0]        xbar_sel,
    output logic [NUM_PORTS-1:0]           deq,
    output logic                           err_conflict
);

    localparam int unsigned SW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int unsigned WW = $clog2(WAIT_MAX + 1);

    state_e          state_q, state_d;
    logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            sched_en_q, sched_en_d;
    logic            err_q, err_d;

    logic                 capture;
    logic                 step;
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] discard;
    logic [NUM_PORTS-1:0] grant_ok;
    logic [NUM_PORTS-1:0] active;

    assign capture = (state_q == ST_WAIT) && sched_sel_en;
    assign step    = (state_q == ST_XFER);

    // Only idle ingresses with a non-empty granted VOQ may take a new packet.
    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++)
            cand[i] = !is_busy[i] && !voq_empty[NUM_PORTS*i + sched_sel[PW*i +: PW]];
    end

    assign discard  = egress_conflict(sched_sel, cand);
    assign grant_ok = cand & ~discard;

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q | (capture && (discard != '0));
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_REQ;
            ST_REQ: begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                if (sched_sel_en || (wait_cnt_q == WW'(WAIT_MAX - 1))) begin
                    state_d    = ST_XFER;
                    slot_cnt_d = SW'(SLOT_LEN - 1);
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            ST_XFER: begin
                if (slot_cnt_q == '0)
                    state_d = enable ? ST_REQ : ST_IDLE;
                else
                    slot_cnt_d = slot_cnt_q - SW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        sched_en_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            slot_cnt_q <= '0;
            wait_cnt_q <= '0;
            sched_en_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            sched_en_q <= sched_en_d;
            err_q      <= err_d;
        end
    end

    assign sched_en     = sched_en_q;
    assign err_conflict = err_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        port_xfer u_port (
            .clk      (clk),
            .reset_n  (reset_n),
            .load     (capture && grant_ok[g]),
            .load_voq (sched_sel[PW*g +: PW]),
            .load_len (head_len[LEN_W*g +: LEN_W]),
            .step     (step),
            .busy     (is_busy[g]),
            .active   (active[g]),
            .deq      (deq[g]),
            .voq      (busy_voq_num[PW*g +: PW])
        );
    end

    always_comb begin
        xbar_valid = '0;
        xbar_sel   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (active[i]) begin
                xbar_valid[busy_voq_num[PW*i +: PW]]       = 1'b1;
                xbar_sel[PW*busy_voq_num[PW*i +: PW] +: PW] = PW'(i);
            end
        end
    end

endmodule

// File: tb/tb_xfer_ctrl.sv
// Randomized bench for xfer_ctrl: a packet-level model predicts every crossbar
// cycle and dequeue, and a monitor compares them against the DUT as they appear.
`timescale 1ns/1ps
module tb_xfer_ctrl;
    import xfer_pkg::*;

    localparam int SLOT = 8;
    localparam int WMAX = 16;
    localparam int NP   = 4;
    localparam int NSLOTS = 40;

    logic        clk = 1'b0;
    logic        reset_n, enable, sched_sel_en;
    logic [15:0] voq_empty;
    logic [23:0] head_len;
    logic [7:0]  sched_sel;
    logic        sched_en, err_conflict;
    logic [3:0]  is_busy, xbar_valid, deq;
    logic [7:0]  busy_voq_num, xbar_sel;

    xfer_ctrl #(.SLOT_LEN(SLOT), .WAIT_MAX(WMAX)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .voq_empty    (voq_empty),
        .head_len     (head_len),
        .sched_sel_en (sched_sel_en),
        .sched_sel    (sched_sel),
        .sched_en     (sched_en),
        .is_busy      (is_busy),
        .busy_voq_num (busy_voq_num),
        .xbar_valid   (xbar_valid),
        .xbar_sel     (xbar_sel),
        .deq          (deq),
        .err_conflict (err_conflict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] valid;
        logic [7:0] sel;
        logic [3:0] deq;
    } rec_t;

    rec_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Packet-level model: words left and VOQ per ingress, sticky conflict flag.
    int m_rem[NP];
    int m_voq[NP];
    bit m_err;
    int exp_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic [5:0] pick_len();
        case ($urandom_range(0, 5))
            0: return 6'd0;
            1: return 6'd3;
            2: return 6'd11;
            3: return 6'd1;
            4: return 6'd8;
            default: return 6'($urandom_range(0, 40));
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_rem[i] = 0;
            m_voq[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_capture(input logic [7:0] s, input logic [15:0] em, input logic [23:0] l);
        bit taken[NP];
        int e;
        for (int i = 0; i < NP; i++) taken[i] = 0;
        for (int i = 0; i < NP; i++) begin
            if (m_rem[i] == 0) begin
                e = int'(s[2*i +: 2]);
                if (!em[4*i + e]) begin
                    if (taken[e]) m_err = 1;
                    else begin
                        taken[e] = 1;
                        m_rem[i] = (l[6*i +: 6] == 0) ? 1 : int'(l[6*i +: 6]);
                        m_voq[i] = e;
                    end
                end
            end
        end
    endtask

    task automatic gen_slot(input int start, input int ncyc);
        rec_t r;
        for (int c = 0; c < ncyc; c++) begin
            r.cyc = start + c;
            r.valid = '0;
            r.sel = '0;
            r.deq = '0;
            for (int i = 0; i < NP; i++) begin
                if (m_rem[i] > 0) begin
                    r.valid[m_voq[i]] = 1'b1;
                    r.sel[2*m_voq[i] +: 2] = 2'(i);
                    m_rem[i]--;
                    if (m_rem[i] == 0) r.deq[i] = 1'b1;
                end
            end
            if (r.valid != '0) exp_q.push_back(r);
        end
    endtask

    task automatic randomize_idle_inputs();
        sched_sel_en = 1'($urandom);
        sched_sel    = 8'($urandom);
        voq_empty    = 16'($urandom);
        head_len     = 24'($urandom);
    endtask

    task automatic make_grant();
        logic [7:0]  s;
        logic [15:0] e;
        logic [23:0] l;
        s = 8'($urandom);
        e = 16'($urandom & $urandom);
        if ($urandom_range(0, 2) == 0) s[5:4] = s[3:2];
        for (int i = 0; i < NP; i++) begin
            l[6*i +: 6] = pick_len();
            // sched never grants an egress already held by an in-flight packet
            if (m_rem[i] == 0)
                for (int j = 0; j < NP; j++)
                    if (m_rem[j] > 0 && m_voq[j] == int'(s[2*i +: 2])) e[4*i + int'(s[2*i +: 2])] = 1'b1;
        end
        sched_sel = s;
        voq_empty = e;
        head_len  = l;
        sched_sel_en = 1'b1;
        model_capture(s, e, l);
    endtask

    task automatic wait_req();
        int b = 0;
        while (!sched_en && b < 60) begin
            randomize_idle_inputs();
            @(negedge clk);
            b++;
        end
        chk("req_seen", 64'(sched_en), 64'd1);
        chk("req_cycle", 64'(cyc), 64'(exp_req));
    endtask

    task automatic run_slot(input bit abort);
        logic [3:0] eb;
        logic [7:0] ev;
        int  d, start, last;
        bit  grant, park;
        wait_req();
        for (int i = 0; i < NP; i++) begin
            eb[i] = (m_rem[i] > 0);
            ev[2*i +: 2] = 2'(m_voq[i]);
        end
        chk("is_busy", 64'(is_busy), 64'(eb));
        chk("busy_voq_num", 64'(busy_voq_num), 64'(ev));
        chk("err_conflict", 64'(err_conflict), 64'(m_err));
        park  = !abort && ($urandom_range(0, 3) == 0);
        d     = abort ? 0 : $urandom_range(0, WMAX + 3);
        grant = (d < WMAX);
        randomize_idle_inputs();
        voq_empty = '0;
        if (park) enable = 1'b0;
        start = 0;
        for (int w = 1; w <= WMAX; w++) begin
            @(negedge clk);
            if (w == 1) chk("sched_en_pulse", 64'(sched_en), 64'd0);
            if (grant && w == d + 1) begin
                make_grant();
                start = cyc + 1;
                break;
            end
            randomize_idle_inputs();
            sched_sel_en = 1'b0;
            if (w == WMAX) start = cyc + 1;
        end
        last = start + SLOT - 1;
        if (abort) begin
            gen_slot(start, 4);
            while (cyc < start + 3) begin
                @(negedge clk);
                randomize_idle_inputs();
            end
            reset_n = 1'b0;
            @(negedge clk);
            chk("mid_slot_reset", 64'({sched_en, is_busy, busy_voq_num, xbar_valid, xbar_sel, deq, err_conflict}), 64'd0);
            model_reset();
            reset_n = 1'b1;
            enable = 1'b0;
            return;
        end
        gen_slot(start, SLOT);
        @(negedge clk);
        randomize_idle_inputs();
        if (park) begin
            while (cyc < last + 3) begin
                @(negedge clk);
                randomize_idle_inputs();
            end
            enable = 1'b1;
            exp_req = last + 4;
        end else begin
            exp_req = last + 1;
        end
    endtask

    // Monitor: every crossbar cycle the DUT presents must match the next predicted one.
    always @(negedge clk) begin
        rec_t r;
        if (xbar_valid != '0 || deq != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", 64'({xbar_valid, xbar_sel, deq}), 64'd0);
            end else begin
                r = exp_q.pop_front();
                chk("xfer_cycle", 64'(cyc), 64'(r.cyc));
                chk("xfer_word", 64'({xbar_valid, xbar_sel, deq}), 64'({r.valid, r.sel, r.deq}));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        sched_sel_en = 1'b0;
        voq_empty = '1;
        head_len = '0;
        sched_sel = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({sched_en, is_busy, busy_voq_num, xbar_valid, xbar_sel, deq, err_conflict}), 64'd0);
        reset_n = 1'b1;
        enable = 1'b1;
        exp_req = cyc + 1;
        for (int s = 0; s < NSLOTS; s++) run_slot(1'b0);
        enable = 1'b1;
        run_slot(1'b1);
        @(negedge clk);
        chk("idle_after_reset", 64'(sched_en), 64'd0);
        enable = 1'b1;
        exp_req = cyc + 1;
        for (int s = 0; s < 4; s++) run_slot(1'b0);
        enable = 1'b0;
        repeat (SLOT + WMAX + 6) @(negedge clk);
        chk("parked_no_req", 64'(sched_en), 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
